// File: rtl/oled_pkg.sv
// Shared types for the PMOD OLED SPI receiver: power states,
// byte width and the FIFO entry layout.
package oled_pkg;

    localparam int OLED_BYTE_W = 8;

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        VDD_ON   = 3'd1,
        IN_RESET = 3'd2,
        READY    = 3'd3,
        DISPLAY  = 3'd4
    } pwr_state_t;

    typedef struct packed {
        logic                   dc;
        logic [OLED_BYTE_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/oled_if.sv
// PMOD OLED control/data lines. The SPI clock travels separately.
interface oled_if;
    logic cs;
    logic mosi;
    logic dc_c;
    logic res;
    logic vss_en;
    logic pmod_en;

    modport master (
        output cs, mosi, dc_c, res, vss_en, pmod_en
    );

    modport slave (
        input cs, mosi, dc_c, res, vss_en, pmod_en
    );
endinterface

// File: rtl/oled_byte_fifo.sv
// Byte FIFO with a registered head; the output register is a view
// of the oldest entry, so capacity is DEPTH entries in total.
module oled_byte_fifo
    import oled_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t push_entry,
    output logic        accepted,
    output logic        dropped,
    output logic        m_valid,
    input  logic        m_ready,
    output fifo_entry_t m_entry
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t     mem [DEPTH];
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   wr_q;
    logic [AW:0]     cnt_q;
    logic [AW-1:0]   rd_d;
    logic [AW:0]     remain;
    logic            pop;
    logic            full;

    assign pop      = m_valid & m_ready;
    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign accepted = push & (~full | pop);
    assign dropped  = push & full & ~pop;
    assign rd_d     = rd_q + AW'(pop);
    assign remain   = cnt_q - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (accepted) begin
            mem[wr_q] <= push_entry;
        end
    end

    // The head reloads from entries already stored, never from this
    // cycle's push, which keeps the write-to-valid delay fixed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            m_valid <= 1'b0;
            m_entry <= '0;
        end else begin
            wr_q    <= wr_q + AW'(accepted);
            rd_q    <= rd_d;
            cnt_q   <= remain + (AW+1)'(accepted);
            m_valid <= (remain != '0);
            if (remain != '0) begin
                m_entry <= mem[rd_d];
            end
        end
    end

endmodule

// File: rtl/oled_spi_rx.sv
// Slave-side SPI receiver and protocol checker for the PMOD OLED
// link: deserialiser, power-sequence tracker and byte FIFO.
module oled_spi_rx
    import oled_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int RES_MIN_CYC = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    oled_if.slave       oled,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_dc,
    output pwr_state_t  pwr_state,
    output logic        err_partial,
    output logic        err_overflow,
    output logic        err_seq,
    output logic [15:0] byte_count
);

    localparam int I_SCLK = 0;
    localparam int I_CS   = 1;
    localparam int I_MOSI = 2;
    localparam int I_DC   = 3;
    localparam int I_RES  = 4;
    localparam int I_VSS  = 5;
    localparam int I_PMOD = 6;
    localparam int RCW    = $clog2(RES_MIN_CYC + 1);

    logic [6:0]   raw;
    logic [6:0]   sync_q [SYNC_STAGES];
    logic [6:0]   s;
    logic         sclk_prev;
    logic         cs_prev;
    logic         sclk_rise;
    logic         cs_rise;
    logic         hold;
    logic         byte_done;
    logic [7:0]   shift_q;
    logic [2:0]   bit_cnt;
    pwr_state_t   state_q;
    pwr_state_t   state_d;
    logic         fsm_err;
    logic [RCW-1:0] res_cnt;
    fifo_entry_t  push_entry;
    fifo_entry_t  head;
    logic         accepted;
    logic         dropped;
    logic         seq_byte;

    assign raw = {oled.pmod_en, oled.vss_en, oled.res,
                  oled.dc_c, oled.mosi, oled.cs, sclk};
    assign s   = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sclk_prev <= s[I_SCLK];
            cs_prev   <= s[I_CS];
        end
    end

    assign sclk_rise = s[I_SCLK] & ~sclk_prev;
    assign cs_rise   = s[I_CS] & ~cs_prev;
    assign hold      = s[I_CS] | (state_q == OFF) | (state_q == IN_RESET);
    assign byte_done = sclk_rise & ~hold & (bit_cnt == 3'd7);

    assign push_entry.dc   = s[I_DC];
    assign push_entry.data = {shift_q[6:0], s[I_MOSI]};
    assign seq_byte = byte_done & ~(state_q inside {READY, DISPLAY});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q     <= '0;
            bit_cnt     <= '0;
            err_partial <= 1'b0;
        end else begin
            err_partial <= cs_rise & (bit_cnt != 3'd0);
            if (hold) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift_q <= {shift_q[6:0], s[I_MOSI]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fsm_err = 1'b0;
        if (s[I_VSS] && (state_q inside {OFF, VDD_ON, IN_RESET})) begin
            fsm_err = 1'b1;
        end
        if (!s[I_PMOD]) begin
            state_d = OFF;
        end else begin
            unique case (state_q)
                OFF: state_d = VDD_ON;
                VDD_ON: begin
                    if (!s[I_RES]) state_d = IN_RESET;
                end
                IN_RESET: begin
                    if (s[I_RES]) begin
                        if (res_cnt >= RCW'(RES_MIN_CYC)) begin
                            state_d = READY;
                        end else begin
                            state_d = VDD_ON;
                            fsm_err = 1'b1;
                        end
                    end
                end
                READY: begin
                    if (!s[I_RES])     state_d = IN_RESET;
                    else if (s[I_VSS]) state_d = DISPLAY;
                end
                DISPLAY: begin
                    if (!s[I_RES]) begin
                        state_d = IN_RESET;
                        fsm_err = 1'b1;
                    end else if (!s[I_VSS]) begin
                        state_d = READY;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Counts IN_RESET cycles seen with res low, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= OFF;
            res_cnt      <= '0;
            err_seq      <= 1'b0;
            err_overflow <= 1'b0;
            byte_count   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != IN_RESET) begin
                res_cnt <= '0;
            end else if (!s[I_RES] && res_cnt != RCW'(RES_MIN_CYC)) begin
                res_cnt <= res_cnt + RCW'(1);
            end
            err_seq      <= err_seq | fsm_err | seq_byte;
            err_overflow <= err_overflow | dropped;
            byte_count   <= byte_count + 16'(accepted);
        end
    end

    oled_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (byte_done),
        .push_entry (push_entry),
        .accepted   (accepted),
        .dropped    (dropped),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_entry    (head)
    );

    assign m_data    = head.data;
    assign m_dc      = head.dc;
    assign pwr_state = state_q;

endmodule
